alu_iter_exec: RTL and testbench



---
 rtl/alu_iter_exec_if.sv | 25 ++
 rtl/alu_iter_exec.sv | 140 ++++++++++++++
 tb/tb_alu_iter_exec.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_iter_exec_if.sv
// Request/response bundle between the ALU control decoder and alu_iter_exec.
interface alu_iter_exec_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      ctrl;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    modport master (
        output in_valid, ctrl, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, ctrl, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_iter_exec.sv
// ALU execute stage: single-cycle logic/arith/compare, bit-serial shifts.
// Define FAST_SHIFT_EN to replace the bit-serial shifter with a one-cycle barrel shifter.
module alu_iter_exec #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic           clk,
    input  logic           reset,
    alu_iter_exec_if.slave bus
);
    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_SLL  = 4'b0011;
    localparam logic [3:0] CTRL_SLT  = 4'b0100;
    localparam logic [3:0] CTRL_SLTU = 4'b0101;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_XOR  = 4'b0111;
    localparam logic [3:0] CTRL_SRL  = 4'b1000;
    localparam logic [3:0] CTRL_SRA  = 4'b1010;

`ifdef FAST_SHIFT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

    localparam logic [1:0] SH_SLL = 2'd0;
    localparam logic [1:0] SH_SRL = 2'd1;
    localparam logic [1:0] SH_SRA = 2'd2;

    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]         shtype_q, shtype_d;
`endif

    state_t          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;
    logic            in_ready_q, out_valid_q;
    logic [SHAMT_W-1:0] shamt;

    assign shamt         = bus.op_b[SHAMT_W-1:0];
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;

    // State and output registers; result_q doubles as the shift working register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifndef FAST_SHIFT_EN
            cnt_q       <= '0;
            shtype_q    <= SH_SLL;
`endif
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
`ifndef FAST_SHIFT_EN
            cnt_q       <= cnt_d;
            shtype_q    <= shtype_d;
`endif
        end
    end

    // Next-state and datapath.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
`ifndef FAST_SHIFT_EN
        cnt_d     = cnt_q;
        shtype_d  = shtype_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d   = DONE;
                    illegal_d = 1'b0;
                    case (bus.ctrl)
                        CTRL_ADD:  result_d = bus.op_a + bus.op_b;
                        CTRL_SUB:  result_d = bus.op_a - bus.op_b;
                        CTRL_AND:  result_d = bus.op_a & bus.op_b;
                        CTRL_OR:   result_d = bus.op_a | bus.op_b;
                        CTRL_XOR:  result_d = bus.op_a ^ bus.op_b;
                        CTRL_SLT:  result_d = XLEN'($signed(bus.op_a) < $signed(bus.op_b));
                        CTRL_SLTU: result_d = XLEN'(bus.op_a < bus.op_b);
`ifdef FAST_SHIFT_EN
                        CTRL_SLL:  result_d = bus.op_a << shamt;
                        CTRL_SRL:  result_d = bus.op_a >> shamt;
                        CTRL_SRA:  result_d = $unsigned($signed(bus.op_a) >>> shamt);
`else
                        CTRL_SLL, CTRL_SRL, CTRL_SRA: begin
                            result_d = bus.op_a;
                            if (shamt != '0) begin
                                state_d  = SHIFT;
                                cnt_d    = shamt;
                                shtype_d = (bus.ctrl == CTRL_SLL) ? SH_SLL :
                                           (bus.ctrl == CTRL_SRL) ? SH_SRL : SH_SRA;
                            end
                        end
`endif
                        default: begin
                            result_d  = '0;
                            illegal_d = 1'b1;
                        end
                    endcase
                    zero_d = (result_d == '0);
                end
            end
`ifndef FAST_SHIFT_EN
            SHIFT: begin
                case (shtype_q)
                    SH_SRL:  result_d = {1'b0, result_q[XLEN-1:1]};
                    SH_SRA:  result_d = {result_q[XLEN-1], result_q[XLEN-1:1]};
                    default: result_d = {result_q[XLEN-2:0], 1'b0};
                endcase
                zero_d = (result_d == '0);
                cnt_d  = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) state_d = DONE;
            end
`endif
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_alu_iter_exec.sv
// Scoreboard bench for alu_iter_exec: directed plan cases, random ops, reset mid-shift.
module tb_alu_iter_exec;
    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic        illegal;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];

    alu_iter_exec_if #(.XLEN(32)) bus ();

    alu_iter_exec #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic is_shift(input logic [3:0] c);
        return (c == 4'b0011) || (c == 4'b1000) || (c == 4'b1010);
    endfunction

    function automatic logic is_illegal(input logic [3:0] c);
        case (c)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
            4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1010: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    // Reference model written independently of the RTL datapath.
    function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] s;
        s = b[4:0];
        case (c)
            4'b0010: return a + b;
            4'b0110: return a + ~b + 32'd1;
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0111: return a ^ b;
            4'b0100: return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
            4'b0101: return {31'd0, (a < b)};
            4'b0011: return a << s;
            4'b1000: return a >> s;
            4'b1010: return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
            default: return 32'd0;
        endcase
    endfunction

    // One transaction: drive, push expectation, measure latency, optional back-pressure, pop and compare.
    task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int hold);
        exp_t e;
        exp_t got_e;
        int   lat;
        int   exp_lat;
        logic [31:0] r0;
        e.result  = exp_res;
        e.zero    = (exp_res == 32'd0);
        e.illegal = is_illegal(c);
        exp_lat   = 1;
`ifndef FAST_SHIFT_EN
        if (is_shift(c)) exp_lat = 1 + int'(b[4:0]);
`endif
        sb.push_back(e);

        @(negedge clk);
        check_eq("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.ctrl      = c;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        #1;
        // Scramble inputs after accept; captured operands must be used.
        bus.in_valid = 1'b0;
        bus.ctrl     = 4'($urandom);
        bus.op_a     = $urandom;
        bus.op_b     = $urandom;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            check_eq("in_ready_busy", 32'(bus.in_ready), 32'd0);
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            lat++;
        end
        check_eq("out_valid_seen", 32'(bus.out_valid), 32'd1);
        check_eq("latency", 32'(lat), 32'(exp_lat));

        got_e = sb.pop_front();
        r0 = bus.result;
        for (int i = 0; i < hold; i++) begin
            check_eq("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check_eq("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check_eq("bp_result_stable", bus.result, r0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        check_eq("result", bus.result, got_e.result);
        check_eq("zero", 32'(bus.zero), 32'(got_e.zero));
        check_eq("illegal", 32'(bus.illegal), 32'(got_e.illegal));
        @(posedge clk);
        #1;
        check_eq("out_valid_after_handoff", 32'(bus.out_valid), 32'd0);
        check_eq("in_ready_after_handoff", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        check_eq({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check_eq({tag, "_result"}, bus.result, 32'd0);
        check_eq({tag, "_zero"}, 32'(bus.zero), 32'd0);
        check_eq({tag, "_illegal"}, 32'(bus.illegal), 32'd0);
    endtask

    initial begin
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        n_checks = 0;
        n_errors = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.ctrl      = 4'd0;
        bus.op_a      = 32'd0;
        bus.op_b      = 32'd0;
        bus.out_ready = 1'b0;
        #1;
        check_reset_state("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_op(4'b0010, 32'd5, 32'd7, 32'd12, 0);
        run_op(4'b0110, 32'h1234, 32'h1234, 32'd0, 0);
        run_op(4'b0110, 32'd0, 32'd1, 32'hFFFF_FFFF, 0);
        run_op(4'b0100, 32'hFFFF_FFFF, 32'd1, 32'd1, 0);
        run_op(4'b0101, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
        run_op(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 0);
        run_op(4'b0001, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 0);
        run_op(4'b0111, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 0);
        run_op(4'b1010, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 0);
        run_op(4'b1000, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 0);
        run_op(4'b0011, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 0);
        run_op(4'b0011, 32'h0000_0003, 32'h0000_001F, 32'h8000_0000, 0);
        run_op(4'b1010, 32'h4000_0000, 32'h0000_001E, 32'h0000_0001, 0);
        run_op(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 5);
        run_op(4'b1001, 32'd1, 32'd2, 32'd0, 0);
        run_op(4'b1010, 32'hF000_000F, 32'h0000_0003, 32'hFE00_0001, 3);

        for (int i = 0; i < 40; i++) begin
            c = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            if (i % 8 == 0) b = a;
            run_op(c, a, b, model(c, a, b), int'($urandom_range(0, 2)));
        end

        // Reset during an in-flight long shift.
`ifdef FAST_SHIFT_EN
        run_op(4'b0011, 32'h0000_0001, 32'd20, 32'h0010_0000, 0);
`else
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.ctrl      = 4'b0011;
        bus.op_a      = 32'h0000_0001;
        bus.op_b      = 32'd20;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check_eq("midshift_out_valid_low", 32'(bus.out_valid), 32'd0);
        reset = 1'b1;
        #1;
        check_reset_state("midshift_reset");
        @(negedge clk);
        reset = 1'b0;
`endif
        run_op(4'b0010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 0);

        check_eq("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
